// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: sweep/run state encoding,
// write-port count and the depth helper.
package regfile_pkg;

  localparam int NUM_WR = 2;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for in-flight producers. Reservation beats a
// same-cycle write; REGFILE_BYPASS_EN enables same-cycle forwarding of pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           run,
  input  logic                           rsv_en,
  input  logic [ADDR_W-1:0]              rsv_addr,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0]              rd_pend
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0] pend_q;
  logic             rsv_ok;

  assign rsv_ok = run && rsv_en && (rsv_addr != '0);

  // Set is applied after the clears so a new producer's reservation sticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else if (run) begin
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en[p]) pend_q[wr_addr[p]] <= 1'b0;
      if (rsv_ok) pend_q[rsv_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_pend = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (run && (rd_addr[k] != '0)) begin
        rd_pend[k] = pend_q[rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NUM_WR; p++)
          if (wr_en[p] && (wr_addr[p] == rd_addr[k]))
            rd_pend[k] = rsv_ok && (rsv_addr == rd_addr[k]);
`endif
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised writes,
// pending scoreboard and post-reset clear sweep. Option macro: REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       init_done,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [NUM_RD-1:0][ADDR_W-1:0] ra;
  logic [NUM_RD-1:0][DATA_W-1:0] rd;
  logic [NUM_WR-1:0][ADDR_W-1:0] wa;
  logic [NUM_WR-1:0][DATA_W-1:0] wd;

  assign ra      = rd_addr;
  assign wa      = wr_addr;
  assign wd      = wr_data;
  assign rd_data = rd;

  logic [0:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // init_done trails the RUN transition by one edge so it rises on edge DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_CLEAR;
      idx       <= ADDR_W'(1);
      init_done <= 1'b0;
    end else begin
      init_done <= (state == ST_RUN);
      if (state == ST_CLEAR) begin
        if (idx == '1) state <= ST_RUN;
        else           idx   <= idx + ADDR_W'(1);
      end
    end
  end

  // Array has no reset; the sweep zeroes it. Port 1 is written last and wins.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[idx] <= '0;
    end else if (init_done) begin
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en[p] && (wa[p] != '0)) mem[wa[p]] <= wd[p];
    end
  end

  always_comb begin
    rd = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (init_done && (ra[k] != '0)) begin
        rd[k] = mem[ra[k]];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NUM_WR; p++)
          if (wr_en[p] && (wa[p] == ra[k])) rd[k] = wd[p];
`endif
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (init_done),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wa),
    .rd_addr  (ra),
    .rd_pend  (rd_pend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (DATA_W=32, ADDR_W=5, NUM_RD=2): sweep timing,
// write/reserve vectors, bypass behaviour and mid-sweep reset.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init_done;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_done (init_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_pend   (rd_pend),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  typedef struct {
    logic        rsv;
    logic [4:0]  rsv_a;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic        ep0;
    logic [31:0] ed1;
    logic        ep1;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic idle();
    rsv_en = 1'b0; rsv_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic run_sweep(input string tag);
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      if (e == 31) idle();
      chk($sformatf("%s init_done edge%0d", tag, e), {63'd0, init_done}, {63'd0, (e == 32)});
    end
  endtask

  initial begin
    vec[0]  = '{0, 0,  2'b01, 5,  32'hDEADBEEF, 0,  0,         5,  0,  32'hDEADBEEF, 0, 0,            0};
    vec[1]  = '{0, 0,  2'b01, 0,  32'h1234,     0,  0,         0,  5,  0,            0, 32'hDEADBEEF, 0};
    vec[2]  = '{0, 0,  2'b11, 7,  32'h1111,     7,  32'h2222,  7,  5,  32'h2222,     0, 32'hDEADBEEF, 0};
    vec[3]  = '{1, 9,  2'b00, 0,  0,            0,  0,         9,  7,  0,            1, 32'h2222,     0};
    vec[4]  = '{0, 0,  2'b10, 0,  0,            9,  32'h55,    9,  0,  32'h55,       0, 0,            0};
    vec[5]  = '{1, 9,  2'b01, 9,  32'h66,       0,  0,         9,  5,  32'h66,       1, 32'hDEADBEEF, 0};
    vec[6]  = '{1, 0,  2'b00, 0,  0,            0,  0,         0,  9,  0,            0, 32'h66,       1};
    vec[7]  = '{0, 0,  2'b11, 10, 32'hAAAA,     11, 32'hBBBB,  10, 11, 32'hAAAA,     0, 32'hBBBB,     0};
    vec[8]  = '{0, 0,  2'b01, 31, 32'hFFFFFFFF, 0,  0,         31, 1,  32'hFFFFFFFF, 0, 0,            0};
    vec[9]  = '{0, 0,  2'b10, 0,  0,            9,  0,         9,  10, 0,            0, 32'hAAAA,     0};
    vec[10] = '{1, 13, 2'b01, 14, 32'h4444,     0,  0,         13, 14, 0,            1, 32'h4444,     0};
    vec[11] = '{0, 0,  2'b01, 4,  32'h99,       0,  0,         4,  13, 32'h99,       0, 0,            1};
    vec[12] = '{0, 0,  2'b10, 0,  0,            3,  32'h0BAD,  3,  4,  32'h0BAD,     0, 32'h99,       0};

    // Reset state
    reset_n = 1'b0;
    idle();
    rd_addr = {5'd9, 5'd5};
    repeat (2) @(posedge clk);
    #1;
    chk("reset init_done", {63'd0, init_done}, 64'd0);
    chk("reset rd_data", rd_data, 64'd0);
    chk("reset rd_pend", {62'd0, rd_pend}, 64'd0);

    // Sweep with writes/reservations to r2 that must be ignored
    @(negedge clk);
    reset_n = 1'b1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd2}; wr_data = {32'd0, 32'hABCD};
    rsv_en = 1'b1; rsv_addr = 5'd2;
    run_sweep("sweep1");

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("post-sweep r%0d", a), {rd_data[62:0], |rd_pend}, 64'd0);
    end

    // Table-driven write / reserve vectors, read back after the edge
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rsv_en  = vec[i].rsv;  rsv_addr = vec[i].rsv_a;
      wr_en   = vec[i].we;
      wr_addr = {vec[i].wa1, vec[i].wa0};
      wr_data = {vec[i].wd1, vec[i].wd0};
      rd_addr = {vec[i].ra1, vec[i].ra0};
      @(posedge clk); #1;
      idle();
      #1;
      chk($sformatf("vec%0d d0", i), {32'd0, rd_data[31:0]},  {32'd0, vec[i].ed0});
      chk($sformatf("vec%0d p0", i), {63'd0, rd_pend[0]},     {63'd0, vec[i].ep0});
      chk($sformatf("vec%0d d1", i), {32'd0, rd_data[63:32]}, {32'd0, vec[i].ed1});
      chk($sformatf("vec%0d p1", i), {63'd0, rd_pend[1]},     {63'd0, vec[i].ep1});
    end

    // Same-cycle write+reserve to a read address (r3 holds 0x0BAD)
    @(negedge clk);
    rd_addr = {5'd4, 5'd3};
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'hCAFE};
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    chk("byp wr d0", {32'd0, rd_data[31:0]}, BYP ? 64'hCAFE : 64'h0BAD);
    chk("byp wr p0", {63'd0, rd_pend[0]}, BYP ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    idle();
    #1;
    chk("byp after d0", {32'd0, rd_data[31:0]}, 64'hCAFE);
    chk("byp after p0", {63'd0, rd_pend[0]}, 64'd1);

    // Both ports write the read address: port 1 forwarded, pending cleared
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h2, 32'h1};
    #1;
    chk("byp prio d0", {32'd0, rd_data[31:0]}, BYP ? 64'h2 : 64'hCAFE);
    chk("byp prio p0", {63'd0, rd_pend[0]}, BYP ? 64'd0 : 64'd1);
    @(posedge clk); #1;
    idle();
    #1;
    chk("prio after d0", {32'd0, rd_data[31:0]}, 64'h2);
    chk("prio after p0", {63'd0, rd_pend[0]}, 64'd0);

    // Reset in RUN, then again mid-sweep at index 10
    rd_addr = {5'd13, 5'd4};
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst run init_done", {63'd0, init_done}, 64'd0);
    chk("rst run rd_data", rd_data, 64'd0);
    chk("rst run rd_pend", {62'd0, rd_pend}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst mid init_done", {63'd0, init_done}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_sweep("sweep2");
    #1;
    chk("r4 cleared", {32'd0, rd_data[31:0]}, 64'd0);
    chk("r13 pend cleared", {63'd0, rd_pend[1]}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined CPU core, the successor to the single-write/two-read register block. It adds configurable width, depth and read-port count, two write ports with fixed priority, a per-register pending scoreboard for in-flight producers, and a post-reset clear sweep in place of an asynchronous reset of the whole array. It sits between decode (reads, reservations) and writeback (writes, pending clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)

- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- init_done  out  1  high once the post-reset clear sweep is complete
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k in bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_pend  out  NUM_RD  pending flag of the addressed register, combinational
- rsv_en  in  1  reserve destination (set pending)
- rsv_addr  in  ADDR_W  register to reserve
- wr_en  in  2  write enables; port 1 has priority over port 0
- wr_addr  in  2*ADDR_W  write addresses
- wr_data  in  2*DATA_W  write data

## Operation
- Register 0: always reads 0, never pending; writes and reservations to it are dropped.
- States: CLEAR, RUN. Reset forces CLEAR, sweep index = 1, all pending bits = 0, init_done = 0, rd_data = 0, rd_pend = 0.
- CLEAR: each cycle writes 0 to register[index], index increments; after index DEPTH-1 moves to RUN. Writes and reservations are ignored; reads return 0, pend 0.
- RUN: write on wr_en[p] stores wr_data[p] and clears pending[wr_addr[p]]. Both ports same address: port 1 data stored, port 0 discarded.
- Reservation sets pending[rsv_addr]. Reservation and write to same address in the same cycle: data stored, pending ends set (reservation wins — a newer producer is in flight).
- Reads: address 0 -> 0; otherwise array value and pending bit.
- Reset asserted mid-operation (including mid-sweep): immediate return to CLEAR, index 1, sweep restarts after release.

## Timing
- After reset_n rises: sweep occupies DEPTH-1 cycles; init_done high from the DEPTH-th rising edge (32 for ADDR_W=5) and stays high until next reset.
- Write/reservation visible in the array/scoreboard after the rising edge of the issuing cycle.
- Read latency zero (combinational on rd_addr and state).
- With bypass (see Configuration): same-cycle write to the read address is forwarded, highest-priority port's data; rd_pend forced 0 for that read unless a same-cycle reservation targets it (then 1).

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding as in Timing; a same-cycle write is visible on rd_data/rd_pend in that cycle.
- Not defined: reads return the pre-edge array value and pending bit; forwarding is the pipeline's responsibility.

## Structure
- regfile_pkg: state enum (CLEAR, RUN), DEPTH localparam function, write-port count constant (2).
- Sub-module regfile_scoreboard: DEPTH pending bits, async reset, set/clear priority, per-port pending read with optional bypass.

## Test plan
- Reset release, DATA_W=32 ADDR_W=5 -> init_done 0 for 31 cycles, 1 at edge 32; all reads 0 after sweep.
- RUN: write 0xDEADBEEF to r5 via port 0, read r5 next cycle -> 0xDEADBEEF, pend 0; write 0x1234 to r0 -> r0 reads 0.
- Both ports write r7 (port 0 0x1111, port 1 0x2222) -> r7 reads 0x2222.
- Reserve r9 -> rd_pend 1 next cycle; write r9 0x55 -> pend 0; reserve and write r9 same cycle -> data 0x55 stored, pend 1.
- With REGFILE_BYPASS_EN: read r3 while writing 0xCAFE to r3 -> same-cycle rd_data 0xCAFE; without macro -> old value, 0xCAFE next cycle.
- Pulse reset_n low at sweep index 10, then after RUN with r4=0x99 -> init_done drops, sweep restarts from 1, r4 reads 0 after completion.
